// File: rtl/gpio_player_link_rx.sv
// ---------------------------------------------------------------------------
// gpio_player_link_rx
//   Board-1 receiver for the two-board GPIO player link. Raw remote pins are
//   synchronised, glitch-filtered per group (move / colour / play) and gated
//   by a link-state FSM before reaching the game engine. The remote player's
//   score is registered back out to the GPIO header.
//
// Ports
//   i_clock          system clock (50 MHz VGA domain)
//   i_reset          asynchronous, active-low reset
//   i_gpio_move[1:0] raw move pins, [0]=up [1]=down
//   i_gpio_colour[2:0] raw paddle colour pins
//   i_gpio_play      raw play/serve pin
//   i_score_value[3:0] remote score from game engine
//   o_gpio_score[3:0] registered score to remote board
//   o_move_up / o_move_down  filtered, decoded move requests
//   o_colour[2:0]    filtered paddle colour
//   o_play_level     filtered play state (or pause/resume latch, see below)
//   o_play_pulse     one-cycle strobe on accepted play rising edge
//   o_link_up        every input group has settled since reset
//
// Build option
//   PLAY_TOGGLE_EN   when defined, o_play_level toggles on each accepted play
//                    rising edge; otherwise it follows the accepted play pin.
// ---------------------------------------------------------------------------

// Per-group stability filter: a value is accepted once the synchronised
// input has matched the candidate for FILTER_CYCLES consecutive cycles.
module gpio_player_link_rx_filter #(
  parameter int W             = 1,
  parameter int FILTER_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_en,
  input  logic [W-1:0] i_sync,
  output logic [W-1:0] o_acc,
  output logic         o_seen
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

  logic [W-1:0]     r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_acc;
  logic             r_seen;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cand <= '0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_seen <= 1'b0;
    end else if (!i_en || (i_sync != r_cand)) begin
      // While disabled the candidate just tracks the chain so the count
      // starts cleanly once the sync chain has flushed its reset zeros.
      r_cand <= i_sync;
      r_cnt  <= '0;
    end else if (r_cnt < CNT_MAX) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      // Counter saturates here; acceptance repeats harmlessly every cycle.
      r_acc  <= r_cand;
      r_seen <= 1'b1;
    end
  end

  assign o_acc  = r_acc;
  assign o_seen = r_seen;
endmodule

module gpio_player_link_rx #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [1:0] i_gpio_move,
  input  logic [2:0] i_gpio_colour,
  input  logic       i_gpio_play,
  input  logic [3:0] i_score_value,
  output logic [3:0] o_gpio_score,
  output logic       o_move_up,
  output logic       o_move_down,
  output logic [2:0] o_colour,
  output logic       o_play_level,
  output logic       o_play_pulse,
  output logic       o_link_up
);
  typedef enum logic [1:0] {LINK_DOWN, LINK_SYNC, LINK_UP} link_st_e;

  localparam int DN_W = $clog2(SYNC_STAGES + 1);
  localparam logic [DN_W-1:0] DN_LAST = DN_W'(SYNC_STAGES - 1);

  link_st_e r_state, w_next;
  logic [DN_W-1:0] r_dn_cnt;

  // ---- synchroniser: all 6 pin bits, {play, colour, move} ----
  logic [SYNC_STAGES-1:0][5:0] r_sync;
  logic [5:0] w_pins, w_synced;

  assign w_pins   = {i_gpio_play, i_gpio_colour, i_gpio_move};
  assign w_synced = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], w_pins};
  end

  // ---- filters ----
  logic       w_filt_en;
  logic [1:0] w_move_acc;
  logic [2:0] w_colour_acc;
  logic       w_play_acc;
  logic       w_move_seen, w_colour_seen, w_play_seen;

  assign w_filt_en = (r_state != LINK_DOWN);

  gpio_player_link_rx_filter #(.W(2), .FILTER_CYCLES(FILTER_CYCLES), .CNT_W(CNT_W)) u_filt_move (
    .i_clock(i_clock), .i_reset(i_reset), .i_en(w_filt_en),
    .i_sync(w_synced[1:0]), .o_acc(w_move_acc), .o_seen(w_move_seen));

  gpio_player_link_rx_filter #(.W(3), .FILTER_CYCLES(FILTER_CYCLES), .CNT_W(CNT_W)) u_filt_colour (
    .i_clock(i_clock), .i_reset(i_reset), .i_en(w_filt_en),
    .i_sync(w_synced[4:2]), .o_acc(w_colour_acc), .o_seen(w_colour_seen));

  gpio_player_link_rx_filter #(.W(1), .FILTER_CYCLES(FILTER_CYCLES), .CNT_W(CNT_W)) u_filt_play (
    .i_clock(i_clock), .i_reset(i_reset), .i_en(w_filt_en),
    .i_sync(w_synced[5]), .o_acc(w_play_acc), .o_seen(w_play_seen));

  // ---- link FSM: state register ----
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= LINK_DOWN;
      r_dn_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == LINK_DOWN && r_dn_cnt != DN_LAST) r_dn_cnt <= r_dn_cnt + DN_W'(1);
    end
  end

  // ---- link FSM: next state ----
  always_comb begin
    w_next = r_state;
    case (r_state)
      LINK_DOWN: if (r_dn_cnt == DN_LAST) w_next = LINK_SYNC;
      LINK_SYNC: if (w_move_seen && w_colour_seen && w_play_seen) w_next = LINK_UP;
      LINK_UP:   w_next = LINK_UP;
      default:   w_next = LINK_DOWN;
    endcase
  end

  // ---- play edge detect ----
  logic r_play_d;
  logic w_play_rise;

  assign w_play_rise = (r_state == LINK_UP) && w_play_acc && !r_play_d;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_play_d <= 1'b0;
    else          r_play_d <= w_play_acc;
  end

`ifdef PLAY_TOGGLE_EN
  logic r_toggle;
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)         r_toggle <= 1'b0;
    else if (w_play_rise) r_toggle <= ~r_toggle;
  end
`endif

  // ---- link FSM: outputs (everything gated until LINK_UP) ----
  always_comb begin
    o_link_up    = (r_state == LINK_UP);
    o_move_up    = o_link_up && (w_move_acc == 2'b01);
    o_move_down  = o_link_up && (w_move_acc == 2'b10);
    o_colour     = o_link_up ? w_colour_acc : 3'b000;
`ifdef PLAY_TOGGLE_EN
    o_play_level = o_link_up && r_toggle;
`else
    o_play_level = o_link_up && w_play_acc;
`endif
    o_play_pulse = w_play_rise;
  end

  // ---- score path: straight register, no decode glitches on the pins ----
  logic [3:0] r_score;
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_score <= '0;
    else          r_score <= i_score_value;
  end
  assign o_gpio_score = r_score;
endmodule

// File: tb/tb_gpio_player_link_rx.sv
module tb_gpio_player_link_rx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mv = '0;
  logic [2:0] col = '0;
  logic       ply = 1'b0;
  logic [3:0] sc = '0;
  logic [3:0] gpio_score;
  logic       move_up, move_down, play_level, play_pulse, link_up;
  logic [2:0] colour;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gpio_player_link_rx #(.SYNC_STAGES(2), .FILTER_CYCLES(4), .CNT_W(16)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_gpio_move(mv), .i_gpio_colour(col), .i_gpio_play(ply), .i_score_value(sc),
    .o_gpio_score(gpio_score), .o_move_up(move_up), .o_move_down(move_down),
    .o_colour(colour), .o_play_level(play_level), .o_play_pulse(play_pulse),
    .o_link_up(link_up));

  typedef struct {
    logic [1:0] mv;
    logic [2:0] col;
    logic       up;
    logic       dn;
    logic [2:0] ecol;
  } vec_t;
  vec_t tbl[6];

  logic [3:0] sb_q[$];
  logic [3:0] sc_vals[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // All sampling and driving happens at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  function automatic bit probe(input int sel);
    case (sel)
      0:       return link_up;
      1:       return move_up;
      default: return colour == 3'b101;
    endcase
  endfunction

  // Wait (bounded) for a probe to go high; it must land in [lo,hi] cycles.
  task automatic wait_win(input string nm, input int sel, input int lo, input int hi);
    int k;
    bit hit;
    k = 0;
    hit = 0;
    while (!hit && k < hi) begin
      step();
      k++;
      hit = probe(sel);
    end
    chk(nm, {31'd0, hit && (k >= lo)}, 32'd1);
  endtask

  task automatic hold_play(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (play_pulse) pulses++;
    end
  endtask

  initial begin
    int p;
    bit bad_glitch;
    logic [3:0] want;

    tbl[0] = '{mv: 2'b11, col: 3'b000, up: 1'b0, dn: 1'b0, ecol: 3'b000};
    tbl[1] = '{mv: 2'b10, col: 3'b000, up: 1'b0, dn: 1'b1, ecol: 3'b000};
    tbl[2] = '{mv: 2'b00, col: 3'b101, up: 1'b0, dn: 1'b0, ecol: 3'b101};
    tbl[3] = '{mv: 2'b10, col: 3'b011, up: 1'b0, dn: 1'b1, ecol: 3'b011};
    tbl[4] = '{mv: 2'b01, col: 3'b111, up: 1'b1, dn: 1'b0, ecol: 3'b111};
    tbl[5] = '{mv: 2'b00, col: 3'b000, up: 1'b0, dn: 1'b0, ecol: 3'b000};
    sc_vals = '{4'd0, 4'd9, 4'd15, 4'd3, 4'd12, 4'd7, 4'd1, 4'd10};

    // ---- reset state and first settle ----
    step(); step();
    chk("rst link_up", {31'd0, link_up}, 0);
    chk("rst outputs", {24'd0, move_up, move_down, colour, play_level, play_pulse}, 0);
    chk("rst gpio_score", {28'd0, gpio_score}, 0);
    rst_n = 1'b1;
    wait_win("link_up latency", 0, 5, 8);
    chk("settled outputs", {24'd0, move_up, move_down, colour, play_level, play_pulse}, 0);

    // ---- move up latency ----
    mv = 2'b01;
    wait_win("move_up latency", 1, 5, 8);
    chk("move_up down=0", {31'd0, move_down}, 0);

    // ---- decode table, includes simultaneous group changes ----
    for (int v = 0; v < 6; v++) begin
      mv = tbl[v].mv;
      col = tbl[v].col;
      for (int c = 0; c < 10; c++) step();
      chk($sformatf("vec%0d move_up", v), {31'd0, move_up}, {31'd0, tbl[v].up});
      chk($sformatf("vec%0d move_down", v), {31'd0, move_down}, {31'd0, tbl[v].dn});
      chk($sformatf("vec%0d colour", v), {29'd0, colour}, {29'd0, tbl[v].ecol});
    end

    // ---- glitchy colour never accepted, then clean colour accepted ----
    bad_glitch = 0;
    for (int i = 0; i < 24; i++) begin
      col = (i % 3 == 2) ? 3'b000 : 3'b101;
      step();
      if (colour != 3'b000) bad_glitch = 1;
    end
    chk("glitch colour held", {31'd0, bad_glitch}, 0);
    col = 3'b101;
    wait_win("colour latency", 2, 5, 8);
    col = 3'b000;
    for (int c = 0; c < 10; c++) step();

    // ---- play pulse / level ----
    ply = 1'b1;
    hold_play(20, p);
    chk("press1 pulses", p, 1);
    chk("press1 level", {31'd0, play_level}, 1);
    ply = 1'b0;
    hold_play(20, p);
    chk("release1 pulses", p, 0);
`ifdef PLAY_TOGGLE_EN
    chk("release1 level", {31'd0, play_level}, 1);
`else
    chk("release1 level", {31'd0, play_level}, 0);
`endif
    ply = 1'b1;
    hold_play(20, p);
    chk("press2 pulses", p, 1);
`ifdef PLAY_TOGGLE_EN
    chk("press2 level", {31'd0, play_level}, 0);
`else
    chk("press2 level", {31'd0, play_level}, 1);
`endif
    ply = 1'b0;
    hold_play(20, p);
    chk("release2 level", {31'd0, play_level}, 0);

    // ---- score path through scoreboard: one cycle latency ----
    for (int i = 0; i < 8; i++) begin
      sc = sc_vals[i];
      sb_q.push_back(sc_vals[i]);
      step();
      want = sb_q.pop_front();
      chk($sformatf("score[%0d]", i), {28'd0, gpio_score}, {28'd0, want});
    end
    sc = 4'd7;
    step();

    // ---- async reset mid-operation ----
    mv = 2'b01;
    for (int c = 0; c < 10; c++) step();
    chk("pre-reset move_up", {31'd0, move_up}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst outputs", {24'd0, move_up, move_down, colour, play_level, play_pulse}, 0);
    chk("async rst link_up", {31'd0, link_up}, 0);
    chk("async rst score", {28'd0, gpio_score}, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post-rst still down", {31'd0, link_up}, 0);
    chk("post-rst move gated", {31'd0, move_up}, 0);
    wait_win("re-settle link_up", 0, 4, 7);
    chk("re-settle move_up", {31'd0, move_up}, 1);
    chk("re-settle score", {28'd0, gpio_score}, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end
endmodule
